// File: rtl/puzzle_runner_if.sv
// Harness <-> puzzle board and status bundle for puzzle_runner.
// slave: the runner itself; master: whatever drives go and models the board.
interface puzzle_runner_if;
  localparam int unsigned HIST_W  = 8;
  localparam int unsigned COUNT_W = 4;
  localparam int unsigned CYC_W   = 16;

  logic                go;
  logic                start;
  logic                stopped;
  logic                colour;
  logic                busy;
  logic                done;
  logic                pass;
  logic                timeout;
  logic [HIST_W-1:0]   history;
  logic [COUNT_W-1:0]  hist_count;
  logic [CYC_W-1:0]    cycles;

  modport slave (
    input  go, stopped, colour,
    output start, busy, done, pass, timeout, history, hist_count, cycles
  );

  modport master (
    output go, stopped, colour,
    input  start, busy, done, pass, timeout, history, hist_count, cycles
  );
endinterface

// File: rtl/puzzle_runner.sv
// Arms a puzzle board, fires a start pulse, logs colour transitions and
// reports a pass/timeout verdict against a cycle budget.
module puzzle_runner #(
  parameter int unsigned TIMEOUT       = 1024,
  parameter int unsigned START_LEN     = 2,
  parameter bit          EXPECT_COLOUR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  puzzle_runner_if.slave  bus
);

  localparam int unsigned HIST_W  = 8;
  localparam int unsigned COUNT_W = 4;
  localparam int unsigned CYC_W   = 16;
  localparam int unsigned FIRE_W  = 4;

  localparam logic [CYC_W-1:0]   CYC_LAST  = CYC_W'(TIMEOUT - 1);
  localparam logic [CYC_W-1:0]   CYC_MAX   = '1;
  localparam logic [FIRE_W-1:0]  FIRE_LAST = FIRE_W'(START_LEN - 1);
  localparam logic [COUNT_W-1:0] HIST_SAT  = COUNT_W'(HIST_W);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    FIRE = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic stopped_m, stopped_s;
  logic colour_m, colour_s, colour_p;

  logic [FIRE_W-1:0]  fire_cnt, fire_cnt_nxt;
  logic               start_q, start_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic               pass_q, pass_nxt;
  logic               timeout_q, timeout_nxt;
  logic [HIST_W-1:0]  history_q, history_nxt;
  logic [COUNT_W-1:0] hist_count_q, hist_count_nxt;
  logic [CYC_W-1:0]   cycles_q, cycles_nxt;

  logic active_c;
  logic board_stop_c;
  logic expired_c;
  logic launch_c;

  // Two-flop synchronisers for the asynchronous board outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      stopped_m <= 1'b0;
      stopped_s <= 1'b0;
      colour_m  <= 1'b0;
      colour_s  <= 1'b0;
      colour_p  <= 1'b0;
    end else begin
      stopped_m <= bus.stopped;
      stopped_s <= stopped_m;
      colour_m  <= bus.colour;
      colour_s  <= colour_m;
      colour_p  <= colour_s;
    end
  end

  assign active_c     = (state == ARM) || (state == FIRE) || (state == RUN);
  assign launch_c     = ((state == IDLE) || (state == DONE)) && bus.go;
  // A board stop in RUN takes priority over an expiring budget on the same edge
  assign board_stop_c = (state == RUN) && stopped_s;
  assign expired_c    = active_c && (cycles_q == CYC_LAST) && !board_stop_c;

  // State and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fire_cnt     <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      history_q    <= '0;
      hist_count_q <= '0;
      cycles_q     <= '0;
    end else begin
      state        <= state_nxt;
      fire_cnt     <= fire_cnt_nxt;
      start_q      <= start_nxt;
      busy_q       <= busy_nxt;
      done_q       <= done_nxt;
      pass_q       <= pass_nxt;
      timeout_q    <= timeout_nxt;
      history_q    <= history_nxt;
      hist_count_q <= hist_count_nxt;
      cycles_q     <= cycles_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.go) state_nxt = ARM;
      ARM: begin
        if (expired_c)       state_nxt = DONE;
        else if (!stopped_s) state_nxt = FIRE;
      end
      FIRE: begin
        if (expired_c)                  state_nxt = DONE;
        else if (fire_cnt == FIRE_LAST) state_nxt = RUN;
      end
      RUN: if (board_stop_c || expired_c) state_nxt = DONE;
      DONE: if (bus.go) state_nxt = ARM;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    start_nxt      = (state_nxt == FIRE);
    busy_nxt       = (state_nxt == ARM) || (state_nxt == FIRE) || (state_nxt == RUN);
    done_nxt       = (state_nxt == DONE);
    fire_cnt_nxt   = '0;
    pass_nxt       = pass_q;
    timeout_nxt    = timeout_q;
    history_nxt    = history_q;
    hist_count_nxt = hist_count_q;
    cycles_nxt     = cycles_q;

    if ((state == FIRE) && (state_nxt == FIRE)) fire_cnt_nxt = fire_cnt + FIRE_W'(1);

    if (launch_c) begin
      pass_nxt       = 1'b0;
      timeout_nxt    = 1'b0;
      history_nxt    = '0;
      hist_count_nxt = '0;
      cycles_nxt     = '0;
    end

    if (((state == FIRE) || (state == RUN)) && (colour_s != colour_p)) begin
      history_nxt = {history_q[HIST_W-2:0], colour_s};
      if (hist_count_q != HIST_SAT) hist_count_nxt = hist_count_q + COUNT_W'(1);
    end

    // The budget freezes at TIMEOUT-1 when it is what ends the run
    if (active_c && !expired_c && (cycles_q != CYC_MAX)) cycles_nxt = cycles_q + CYC_W'(1);

    if (board_stop_c) begin
      pass_nxt    = (colour_s == EXPECT_COLOUR);
      timeout_nxt = 1'b0;
    end else if (expired_c) begin
      pass_nxt    = 1'b0;
      timeout_nxt = 1'b1;
    end
  end

  assign bus.start      = start_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.timeout    = timeout_q;
  assign bus.history    = history_q;
  assign bus.hist_count = hist_count_q;
  assign bus.cycles     = cycles_q;

endmodule

// File: tb/tb_puzzle_runner.sv
// Directed bench for puzzle_runner: normal, wrong-colour, timeout, stuck board,
// history saturation, go-while-busy and mid-run reset.
module tb_puzzle_runner;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic saw_start;

  puzzle_runner_if bus();
  puzzle_runner_if bus_to();

  puzzle_runner u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  puzzle_runner #(.TIMEOUT(16)) u_dut_to (
    .clk (clk),
    .rst (rst),
    .bus (bus_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    saw_start      = 1'b0;
    rst            = 1'b1;
    bus.go         = 1'b0;
    bus.stopped    = 1'b0;
    bus.colour     = 1'b0;
    bus_to.go      = 1'b0;
    bus_to.stopped = 1'b0;
    bus_to.colour  = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_start", 32'(bus.start), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_pass", 32'(bus.pass), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    chk("rst_history", 32'(bus.history), 0);
    chk("rst_hist_count", 32'(bus.hist_count), 0);
    chk("rst_cycles", 32'(bus.cycles), 0);
    chk("rst_to_busy", 32'(bus_to.busy), 0);
    rst = 1'b0;
    tick();

    // Normal red run: colour up 3 cycles after start, stopped 10 after
    bus.go = 1'b1;
    tick();                                   // edge k
    bus.go = 1'b0;
    chk("red_busy_k", 32'(bus.busy), 1);
    chk("red_done_k", 32'(bus.done), 0);
    chk("red_start_k", 32'(bus.start), 0);
    chk("red_cycles_k", 32'(bus.cycles), 0);
    tick();                                   // k+1
    chk("red_start_k1", 32'(bus.start), 1);
    tick();                                   // k+2
    chk("red_start_k2", 32'(bus.start), 1);
    tick();                                   // k+3
    chk("red_start_k3", 32'(bus.start), 0);
    chk("red_cycles_k3", 32'(bus.cycles), 3);
    tick();                                   // k+4
    bus.colour = 1'b1;
    repeat (7) tick();                        // k+11
    bus.stopped = 1'b1;
    tick();
    tick();                                   // k+13
    chk("red_done_k13", 32'(bus.done), 0);
    chk("red_hist_count_k13", 32'(bus.hist_count), 1);
    tick();                                   // k+14
    chk("red_done", 32'(bus.done), 1);
    chk("red_busy", 32'(bus.busy), 0);
    chk("red_pass", 32'(bus.pass), 1);
    chk("red_timeout", 32'(bus.timeout), 0);
    chk("red_hist_count", 32'(bus.hist_count), 1);
    chk("red_history", 32'(bus.history), 32'h01);
    chk("red_cycles", 32'(bus.cycles), 14);

    // Wrong colour: colour held at 0, restart straight from DONE
    bus.colour  = 1'b0;
    bus.stopped = 1'b0;
    repeat (3) tick();
    bus.go = 1'b1;
    tick();                                   // edge k
    bus.go = 1'b0;
    chk("blue_busy_k", 32'(bus.busy), 1);
    chk("blue_done_k", 32'(bus.done), 0);
    chk("blue_pass_cleared", 32'(bus.pass), 0);
    chk("blue_cycles_cleared", 32'(bus.cycles), 0);
    chk("blue_hist_cleared", 32'(bus.hist_count), 0);
    repeat (11) tick();                       // k+11
    bus.stopped = 1'b1;
    repeat (3) tick();                        // k+14
    chk("blue_done", 32'(bus.done), 1);
    chk("blue_pass", 32'(bus.pass), 0);
    chk("blue_timeout", 32'(bus.timeout), 0);
    chk("blue_hist_count", 32'(bus.hist_count), 0);
    chk("blue_cycles", 32'(bus.cycles), 14);

    // Timeout with TIMEOUT=16, board never stops
    bus_to.go = 1'b1;
    tick();                                   // edge k
    bus_to.go = 1'b0;
    repeat (15) tick();                       // k+15
    chk("to_busy_k15", 32'(bus_to.busy), 1);
    chk("to_done_k15", 32'(bus_to.done), 0);
    chk("to_cycles_k15", 32'(bus_to.cycles), 15);
    tick();                                   // k+16
    chk("to_done", 32'(bus_to.done), 1);
    chk("to_timeout", 32'(bus_to.timeout), 1);
    chk("to_pass", 32'(bus_to.pass), 0);
    chk("to_cycles", 32'(bus_to.cycles), 15);
    chk("to_start", 32'(bus_to.start), 0);
    chk("to_busy", 32'(bus_to.busy), 0);

    // Stuck-stopped board: stays in ARM, start never rises
    bus_to.stopped = 1'b1;
    repeat (3) tick();
    bus_to.go = 1'b1;
    tick();                                   // edge k
    bus_to.go = 1'b0;
    saw_start = bus_to.start;
    repeat (16) begin
      tick();
      saw_start = saw_start | bus_to.start;
    end                                       // k+16
    chk("stuck_saw_start", 32'(saw_start), 0);
    chk("stuck_done", 32'(bus_to.done), 1);
    chk("stuck_timeout", 32'(bus_to.timeout), 1);
    chk("stuck_pass", 32'(bus_to.pass), 0);
    chk("stuck_cycles", 32'(bus_to.cycles), 15);

    // History saturation: 11 toggles 4 cycles apart in RUN, ending at 1
    bus.stopped = 1'b0;
    repeat (3) tick();
    bus.go = 1'b1;
    tick();                                   // edge k
    bus.go = 1'b0;
    repeat (3) tick();                        // k+3, in RUN
    for (int i = 0; i < 11; i++) begin
      bus.colour = ~bus.colour;
      repeat (4) tick();
    end                                       // k+47
    repeat (3) tick();                        // k+50
    chk("sat_hist_count", 32'(bus.hist_count), 8);
    chk("sat_history", 32'(bus.history), 32'h55);
    chk("sat_busy", 32'(bus.busy), 1);
    chk("sat_cycles", 32'(bus.cycles), 50);

    // go while busy is ignored
    bus.go = 1'b1;
    tick();                                   // k+51
    bus.go = 1'b0;
    chk("gobusy_busy", 32'(bus.busy), 1);
    chk("gobusy_cycles", 32'(bus.cycles), 51);
    chk("gobusy_hist_count", 32'(bus.hist_count), 8);
    bus.stopped = 1'b1;
    repeat (3) tick();                        // k+54
    chk("sat_done", 32'(bus.done), 1);
    chk("sat_pass", 32'(bus.pass), 1);
    chk("sat_final_cycles", 32'(bus.cycles), 54);
    chk("sat_final_history", 32'(bus.history), 32'h55);

    // Reset one cycle into FIRE
    bus.stopped = 1'b0;
    repeat (3) tick();
    bus.go = 1'b1;
    tick();                                   // edge k
    bus.go = 1'b0;
    tick();                                   // k+1, FIRE
    chk("rstfire_start_before", 32'(bus.start), 1);
    rst = 1'b1;
    tick();                                   // k+2
    chk("rstfire_start", 32'(bus.start), 0);
    chk("rstfire_busy", 32'(bus.busy), 0);
    chk("rstfire_done", 32'(bus.done), 0);
    chk("rstfire_cycles", 32'(bus.cycles), 0);
    chk("rstfire_history", 32'(bus.history), 0);
    rst = 1'b0;

    // A later go runs normally
    repeat (4) tick();
    bus.go = 1'b1;
    tick();                                   // edge k
    bus.go = 1'b0;
    tick();                                   // k+1
    chk("after_start", 32'(bus.start), 1);
    repeat (4) tick();                        // k+5
    bus.stopped = 1'b1;
    repeat (3) tick();                        // k+8
    chk("after_done", 32'(bus.done), 1);
    chk("after_pass", 32'(bus.pass), 1);
    chk("after_cycles", 32'(bus.cycles), 8);
    chk("after_hist_count", 32'(bus.hist_count), 0);
    chk("after_start_low", 32'(bus.start), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/puzzle_runner.md
# puzzle_runner

Clocked harness stage that drives a puzzle board's `start` input and consumes its `stopped` / `colour` outputs. It arms the board, fires a start pulse, and synchronises the board's asynchronous outputs into `clk`. It logs every colour transition and times the run against a cycle budget. It then reports a pass/fail verdict against an expected final colour. It sits directly around one puzzle instance in the simulation top or the FPGA wrapper.

## Interface
- `TIMEOUT`, default 1024: cycle budget from leaving IDLE. Legal range 4..65535.
- `START_LEN`, default 2: width of the `start` pulse in cycles. Legal range 1..15.
- `EXPECT_COLOUR`, default 1: required synchronised `colour` when the board stops (1 = red, 0 = blue).
- `clk` in 1: single clock.
- `rst` in 1: synchronous reset, active-high.
- `go` in 1: request a run; sampled only in IDLE or DONE.
- `start` out 1: to puzzle `start`; registered.
- `stopped` in 1: from puzzle; asynchronous.
- `colour` in 1: from puzzle; asynchronous.
- `busy` out 1: high in ARM, FIRE and RUN.
- `done` out 1: level, high in DONE.
- `pass` out 1: verdict; valid while `done`.
- `timeout` out 1: budget exhausted; valid while `done`.
- `history` out 8: last 8 logged colours; newest in bit 0.
- `hist_count` out 4: number of logged transitions; saturates at 8.
- `cycles` out 16: cycles elapsed since leaving IDLE; saturates at 65535.

## Operation
- **Input synchronisers.** `stopped` and `colour` each pass through two flops. The results are `stopped_s` and `colour_s`. A third flop `colour_p` holds the previous `colour_s`. All three reset to 0.
- **IDLE.** On `go=1`: clear `history`, `hist_count`, `cycles`, `pass`, `timeout`, and go to ARM.
- **ARM.** Waits for `stopped_s=0`, then goes to FIRE. If the board is still stopped, the cycle budget keeps running.
- **FIRE.** Drives `start=1` for exactly START_LEN cycles, then goes to RUN.
- **RUN.** On `stopped_s=1`, goes to DONE. Latches `pass = (colour_s==EXPECT_COLOUR)` and `timeout=0`.
- **Timeout.** In ARM, FIRE or RUN, when `cycles==TIMEOUT-1`, go to DONE with `timeout=1` and `pass=0`, and force `start` to 0. If timeout and `stopped_s` occur in the same cycle, `stopped_s` wins.
- **DONE.** All results hold. `go=1` restarts exactly as from IDLE.
- **go while busy.** `go` in ARM, FIRE or RUN is ignored.
- **Colour logging.** Active in FIRE and RUN. When `colour_s != colour_p`: `history <= {history[6:0], colour_s}` and `hist_count <= min(hist_count+1, 8)`. Once saturated, shifting continues, so `history` always holds the most recent 8 transitions.
- **Simultaneous events.** If a colour change and `stopped_s` rise occur in the same cycle, the change is logged on that edge and the verdict uses the same `colour_s`.
- **Cycle counter.** `cycles` increments every cycle in ARM, FIRE and RUN, saturates at 65535, and is frozen in DONE.
- **Reset.** `rst` at any time, including mid-run, returns to IDLE on the next edge. All outputs are 0 after that edge, including `start`.

## Timing
- Reset values: `start`, `busy`, `done`, `pass`, `timeout` = 0. `history` = 8'h00, `hist_count` = 0, `cycles` = 0.
- `go` sampled at edge k in IDLE or DONE: `busy=1` and `done=0` after edge k.
- With `stopped` low: ARM lasts at least 1 cycle, so `start` rises after edge k+1. `start` stays high for exactly START_LEN cycles and falls after edge k+1+START_LEN.
- Board outputs reach `stopped_s` / `colour_s` 2 edges after their pins change.
- With `stopped_s` high in RUN at edge m: `done=1`, `busy=0`, and the verdict is valid after edge m.
- Timeout: `done=1` after the edge at which `cycles` was TIMEOUT-1. At that point `cycles` reads TIMEOUT-1.
- No combinational path from any input to any output.

## Test plan
- **Normal red run.** Model board raises `colour` to 1 three cycles after `start` rises, and `stopped` 10 cycles after `start` rises. Pulse `go` → `start` high 2 cycles; `hist_count=1`; `history[0]=1`; `done=1`, `pass=1`, `timeout=0`; `cycles` = exact count from the `go` edge.
- **Wrong colour.** Same stimulus with `colour` held at 0 → `hist_count=0`, `pass=0`, `timeout=0`.
- **Timeout.** TIMEOUT=16 and board never stops → `done` after the 16th busy cycle; `timeout=1`, `pass=0`, `cycles=15`, `start` low.
- **Stuck-stopped board.** `stopped=1` before `go` → remains in ARM with `start` never asserted; ends with `timeout=1`.
- **History saturation.** Toggle `colour` 11 times, 4 cycles apart, in RUN, ending at 1 → `hist_count=8`; `history` equals the alternating pattern of the last 8 transitions, bit 0 = 1.
- **Reset and go-while-busy.** Assert `go` during RUN → no effect. Assert `rst` one cycle into FIRE → all outputs 0 after that edge, and `start` drops on that edge. A later `go` runs normally.
